// File: rtl/asfifo_reader_pkg.sv
`default_nettype none
// ============================================================================
// asfifo_reader_pkg : shared constants and helpers for the async FIFO reader
// Revision: 1.0
// ============================================================================
package asfifo_reader_pkg;

   // Registered read latency of the asynchronous FIFO, in read clocks.
   localparam int ASFIFO_READ_LATENCY = 2;

   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/asfifo_reader_buffer.sv
`default_nettype none
// ============================================================================
// asfifo_reader_buffer : circular skid store with push/pop and occupancy
// Revision: 1.0
// ============================================================================
module asfifo_reader_buffer
   import asfifo_reader_pkg::*;
#(
   parameter int data_width = 8,
   parameter int depth      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [data_width-1:0] push_data,
   input  logic                  pop,
   output logic                  stb,
   output logic [data_width-1:0] data
);
   localparam int c_ptr_w = (depth > 1) ? $clog2(depth) : 1;
   localparam int c_occ_w = credit_width(depth);
   localparam logic [c_occ_w-1:0] c_full = c_occ_w'(depth);
   localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(depth - 1);

   logic [data_width-1:0] r_mem [depth];
   logic [c_ptr_w-1:0]    r_head;
   logic [c_ptr_w-1:0]    r_tail;
   logic [c_occ_w-1:0]    r_occ;

   function automatic logic [c_ptr_w-1:0] wrap_inc(input logic [c_ptr_w-1:0] p);
      return (p == c_last) ? '0 : p + 1'b1;
   endfunction

   assign stb  = (r_occ != '0);
   assign data = r_mem[r_head];

   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_tail] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         assert (!(push && r_occ == c_full));
         if (push) begin
            r_tail <= wrap_inc(r_tail);
         end
         if (pop) begin
            r_head <= wrap_inc(r_head);
         end
         r_occ <= r_occ + c_occ_w'(push) - c_occ_w'(pop);
      end
   end

endmodule
`default_nettype wire

// File: rtl/asfifo_reader.sv
`default_nettype none
// ============================================================================
// asfifo_reader : read-side adapter turning the async FIFO's fixed-latency
//                 read port into a lossless strobe/acknowledge stream
// Revision: 1.0
// ============================================================================
module asfifo_reader
   import asfifo_reader_pkg::*;
#(
   parameter int data_width   = 8,
   parameter int buffer_depth = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [data_width-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_read_en,
   output logic                  stb,
   input  logic                  ack,
   output logic [data_width-1:0] data
);
   localparam int c_cnt_w = credit_width(buffer_depth);
   localparam int c_lat   = ASFIFO_READ_LATENCY;
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(buffer_depth);

   logic [c_cnt_w-1:0] r_cnt;
   logic [c_lat-1:0]   r_inflight;
   logic               w_accept;
   logic               w_pop;

   // Credits cover every in-flight read, so the buffer can never overflow.
   assign fifo_read_en = ~rst & (r_cnt < c_depth);
   assign w_accept     = fifo_read_en & ~fifo_empty;
   assign w_pop        = stb & ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_inflight <= '0;
      end else begin
         assert (r_cnt <= c_depth);
         r_cnt      <= r_cnt + c_cnt_w'(w_accept) - c_cnt_w'(w_pop);
         r_inflight <= {r_inflight[c_lat-2:0], w_accept};
      end
   end

   asfifo_reader_buffer #(
      .data_width (data_width),
      .depth      (buffer_depth)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (r_inflight[c_lat-1]),
      .push_data (fifo_data),
      .pop       (w_pop),
      .stb       (stb),
      .data      (data)
   );

endmodule
`default_nettype wire
